// File: rtl/alsu_result_stage.sv
// Execute-to-writeback stage: buffers ALSU results, owns the CCR and counts retired ops.
// Build option ALSU_RESULT_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module alsu_result_stage #(
    parameter int DATA_W = 16,
    parameter int DEST_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic              in_z,
    input  logic              in_n,
    input  logic              in_c,
    input  logic [2:0]        in_func,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [2:0]        ccr,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              z;
        logic              n;
        logic              c;
        logic [2:0]        func;
    } ent_t;

    state_t           state_q, state_d;
    ent_t             ent0_q, ent0_d;
    ent_t             new_ent;
    logic [2:0]       ccr_q, ccr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             accept;
    logic             retire;
    logic             logic_op;

`ifdef ALSU_RESULT_SKID_EN
    ent_t ent1_q, ent1_d;
    logic in_ready_q, in_ready_d;
    assign in_ready = in_ready_q;
`else
    logic rst_done_q, rst_done_d;
    assign in_ready = rst_done_q & (~out_valid | out_ready);
`endif

    assign new_ent   = '{data: in_r, dest: in_dest, z: in_z, n: in_n, c: in_c, func: in_func};
    assign out_valid = (state_q != EMPTY);
    assign out_data  = ent0_q.data;
    assign out_dest  = ent0_q.dest;
    assign ccr       = ccr_q;
    assign retired   = retired_q;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    // AND/XOR/NOT have no meaningful carry, so the architectural C survives them
    assign logic_op  = (ent0_q.func == 3'd4) | (ent0_q.func == 3'd5) | (ent0_q.func == 3'd6);

    always_comb begin
        state_d   = state_q;
        ent0_d    = ent0_q;
        ccr_d     = ccr_q;
        retired_d = retired_q;
`ifdef ALSU_RESULT_SKID_EN
        ent1_d    = ent1_q;
`else
        rst_done_d = 1'b1;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            if (retire) begin
                ccr_d     = logic_op ? {ent0_q.z, ent0_q.n, ccr_q[0]}
                                     : {ent0_q.z, ent0_q.n, ent0_q.c};
                retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        ent0_d  = new_ent;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        ent0_d = new_ent;
                    end else if (retire) begin
                        state_d = EMPTY;
`ifdef ALSU_RESULT_SKID_EN
                    end else if (accept) begin
                        ent1_d  = new_ent;
                        state_d = TWO;
`endif
                    end
                end
`ifdef ALSU_RESULT_SKID_EN
                TWO: begin
                    if (retire) begin
                        ent0_d  = ent1_q;
                        state_d = ONE;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
`ifdef ALSU_RESULT_SKID_EN
        in_ready_d = (state_d != TWO);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ent0_q     <= '0;
            ccr_q      <= 3'b000;
            retired_q  <= '0;
`ifdef ALSU_RESULT_SKID_EN
            ent1_q     <= '0;
            in_ready_q <= 1'b0;
`else
            rst_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ent0_q     <= ent0_d;
            ccr_q      <= ccr_d;
            retired_q  <= retired_d;
`ifdef ALSU_RESULT_SKID_EN
            ent1_q     <= ent1_d;
            in_ready_q <= in_ready_d;
`else
            rst_done_q <= rst_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_alsu_result_stage.sv
// Bench for alsu_result_stage: directed steps plus random traffic against a queue-based model.
module tb_alsu_result_stage;
`ifdef ALSU_RESULT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_r = '0;
    logic        in_z = 1'b0, in_n = 1'b0, in_c = 1'b0;
    logic [2:0]  in_func = '0;
    logic [2:0]  in_dest = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic [2:0]  ccr;
    logic [15:0] retired;

    alsu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_z(in_z), .in_n(in_n), .in_c(in_c),
        .in_func(in_func), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest),
        .ccr(ccr), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        z, n, c;
        logic [2:0]  func;
    } op_t;

    op_t        mq[$];
    logic [2:0] m_ccr;
    int         m_ret;
    bit         m_rdy_ok;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rdy();
        if (!m_rdy_ok) return 1'b0;
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || (out_ready == 1'b1);
    endfunction

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("out_data", {16'd0, out_data}, {16'd0, mq[0].data});
            chk("out_dest", {29'd0, out_dest}, {29'd0, mq[0].dest});
        end
        chk("ccr", {29'd0, ccr}, {29'd0, m_ccr});
        chk("retired", {16'd0, retired}, m_ret);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy()});
    endtask

    // Called at posedge+1 with inputs already set; checks, then models the next edge.
    task automatic cycle();
        bit  acc, ret;
        op_t nw;
        #3;
        check_all();
        acc = in_valid && exp_rdy();
        ret = (mq.size() > 0) && out_ready;
        nw  = '{data: in_r, dest: in_dest, z: in_z, n: in_n, c: in_c, func: in_func};
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (ret) begin
                op_t h;
                h = mq.pop_front();
                if (h.func == 3'd4 || h.func == 3'd5 || h.func == 3'd6)
                    m_ccr = {h.z, h.n, m_ccr[0]};
                else
                    m_ccr = {h.z, h.n, h.c};
                m_ret = (m_ret + 1) % 65536;
            end
            if (acc) mq.push_back(nw);
        end
        m_rdy_ok = 1'b1;
        #1;
    endtask

    task automatic put(input bit v, input logic [15:0] r, input bit z, input bit n, input bit c,
                       input logic [2:0] f, input logic [2:0] d);
        in_valid = v; in_r = r; in_z = z; in_n = n; in_c = c; in_func = f; in_dest = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1;
        mq.delete(); m_ccr = 3'b000; m_ret = 0; m_rdy_ok = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ccr", {29'd0, ccr}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_dest", {29'd0, out_dest}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_rdy_ok = 1'b1;
        #1;
    endtask

    initial begin
        m_ccr = 3'b000; m_ret = 0; m_rdy_ok = 1'b0;
        #2;
        do_reset();

        // ADD 3+10 -> r=13 into r2
        out_ready = 1'b1;
        put(1, 16'd13, 0, 0, 0, 3'd0, 3'd2);
        cycle();
        put(0, 16'd0, 0, 0, 0, 3'd0, 3'd0);
        #3;
        chk("t2_data", {16'd0, out_data}, 32'd13);
        chk("t2_dest", {29'd0, out_dest}, 32'd2);
        #(-3+3);
        cycle();
        cycle();
        chk("t2_ccr", {29'd0, ccr}, 32'd0);
        chk("t2_retired", {16'd0, retired}, 32'd1);

        // SUB sets C, AND must keep it
        put(1, 16'hFFF9, 0, 1, 1, 3'd1, 3'd3);
        cycle();
        put(1, 16'd2, 0, 0, 0, 3'd4, 3'd4);
        cycle();
        put(0, 16'd0, 0, 0, 0, 3'd0, 3'd0);
        cycle();
        cycle();
        chk("t3_ccr", {29'd0, ccr}, 32'd1);

        // back-pressure with three ops, then drain with third still offered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1, 16'h100 + 16'(i), 0, 0, 1, 3'(i), 3'(i + 5));
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        put(0, 16'd0, 0, 0, 0, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++) cycle();

        // flush with entries held and retire requested in the same cycle
        out_ready = 1'b0;
        put(1, 16'hAAAA, 1, 0, 1, 3'd0, 3'd1);
        cycle();
        put(1, 16'h5555, 0, 1, 0, 3'd7, 3'd6);
        cycle();
        put(0, 16'd0, 0, 0, 0, 3'd0, 3'd0);
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        #3;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_ccr", {29'd0, ccr}, 32'd1);
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom), 3'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            cycle();
        end
        flush = 1'b0;

        // reset with entries held
        out_ready = 1'b0;
        put(1, 16'h1234, 1, 1, 1, 3'd0, 3'd7);
        cycle();
        put(1, 16'h4321, 0, 1, 1, 3'd1, 3'd1);
        cycle();
        do_reset();

        // stream until the counter wraps
        out_ready = 1'b1;
        for (int i = 0; i < 70000 && m_ret != 65535; i++) begin
            put(1, 16'(i), 1'(i), 1'(i >> 1), 1'(i >> 2), 3'(i), 3'(i));
            cycle();
        end
        #3;
        chk("t6_pre", {16'd0, retired}, 32'hFFFF);
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        put(0, 16'd0, 0, 0, 0, 3'd0, 3'd0);
        #3;
        chk("t6_wrap", {16'd0, retired}, 32'd0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
